pipe_stage_regs: RTL
====================

PIPE_STAGE_REGS -- requirements
Module: pipe_stage_regs

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-003 SHALL have port instructionFetch  input  32  instruction word from instruction memory at address pc.
REQ-004 SHALL have port pcenable  input  1  1 = fetch may advance; 0 = hold PC and IF/ID.
REQ-005 SHALL have port idexNOP  input  1  1 = hold PC and IF/ID, inject bubble into ID/EX.
REQ-006 SHALL have port exmemNOP  input  1  1 = hold PC, IF/ID and ID/EX, inject bubble into EX/MEM.
REQ-007 SHALL have port branch_taken  input  1  taken branch/jump resolved for the instruction in EX.
REQ-008 SHALL have port branch_target  input  32  redirect address, valid with branch_taken.
REQ-009 SHALL have port pc  output  32  current fetch address.
REQ-010 SHALL have ports instructionDEC, instructionEX, instructionMEM, instructionWB  output  32 each  IF/ID, ID/EX, EX/MEM and MEM/WB instruction registers.
REQ-011 SHALL have port stage_valid  output  4  {WB,MEM,EX,DEC} valid bits; 0 marks a bubble.
REQ-012 SHALL have port stall_count  output  16  stall-cycle counter (see Configuration).

Function
REQ-013 SHALL update all registers only on rising clk; no combinational input-to-output paths.
REQ-014 SHALL use bubble encoding 32'h0000_0000 with matching stage_valid bit 0.
REQ-015 SHALL evaluate per cycle, in priority order: exmemNOP, then branch_taken, then (idexNOP or !pcenable), then normal advance.
REQ-016 exmemNOP=1: pc, instructionDEC, instructionEX and valid[1:0] hold; EX/MEM <= bubble; MEM/WB <= EX/MEM.
REQ-017 exmemNOP=1 with branch_taken=1: SHALL ignore branch_taken that cycle; the branch is acted on when its EX stage advances.
REQ-018 branch_taken=1 (exmemNOP=0): pc <= branch_target; IF/ID <= bubble; ID/EX <= bubble; EX/MEM <= ID/EX; MEM/WB <= EX/MEM; pcenable and idexNOP are ignored.
REQ-019 idexNOP=1 or pcenable=0 (no higher condition): pc and IF/ID hold; ID/EX <= bubble; EX/MEM and MEM/WB advance.
REQ-020 Normal advance: pc <= pc+4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000); IF/ID <= instructionFetch with valid 1; every downstream stage <= its upstream stage including its valid bit.
REQ-021 A bubble SHALL propagate downstream unchanged: instruction 0, valid 0.
REQ-022 Latency: an instruction fetched without stalls SHALL appear on instructionDEC 1 cycle, instructionEX 2, instructionMEM 3 and instructionWB 4 cycles after capture.

Reset
REQ-023 When rst=1 at a clock edge: pc <= 32'h0000_0000; all four instruction registers <= 0; stage_valid <= 4'b0000; stall_count <= 0; rst has priority over every other input.
REQ-024 Reset asserted mid-stall or mid-branch SHALL discard all in-flight state; the first fetch after release SHALL be from address 0.

Configuration
REQ-025 Macro STALL_COUNT_EN defined: stall_count SHALL increment by 1 each non-reset cycle in which exmemNOP=1, idexNOP=1 or pcenable=0, and SHALL saturate at 16'hFFFF.
REQ-026 Macro STALL_COUNT_EN undefined: stall_count SHALL be constant 0 and the block SHALL contain no counter logic.

Verification
REQ-027 Reset, then pcenable=1 for 4 cycles fetching A,B,C,D -> pc=0x10; DEC=D, EX=C, MEM=B, WB=A; stage_valid=4'b1111.
REQ-028 With DEC=X, EX=Y, pc=0x20, hold pcenable=0 for 2 cycles -> pc=0x20 and DEC=X both cycles; EX bubble then bubble; MEM=Y after the first cycle.
REQ-029 With EX=Y, assert exmemNOP for 1 cycle -> MEM=bubble (valid[2]=0); EX=Y, DEC and pc unchanged; next normal cycle MEM=Y.
REQ-030 With pc=0x40, assert branch_taken with branch_target=0x100 -> pc=0x100; DEC and EX are bubbles; MEM = former EX.
REQ-031 Assert branch_taken and exmemNOP together -> pc holds and the branch is ignored; asserting rst during that cycle -> all outputs reset values.
REQ-032 With STALL_COUNT_EN defined, force stall_count to 0xFFFE and stall 3 cycles -> 0xFFFF, held; with the macro undefined -> stall_count stays 0.

Source files
------------

// File: rtl/pipe_stage_regs.sv
// ---------------------------------------------------------------------------
// pipe_stage_regs
//
// Purpose:
//   Program counter and the four inter-stage instruction registers
//   (IF/ID, ID/EX, EX/MEM, MEM/WB) of a five-stage in-order pipeline.
//   Each stage carries a valid bit. A bubble is instruction 0 with valid 0.
//   All state is registered. No input reaches an output combinationally.
//
// Per-cycle priority (highest first):
//   exmemNOP      : hold PC, IF/ID and ID/EX; bubble into EX/MEM
//   branch_taken  : redirect PC; squash IF/ID and ID/EX
//   idexNOP or !pcenable : hold PC and IF/ID; bubble into ID/EX
//   otherwise     : normal advance, PC += 4 (wraps modulo 2^32)
//
// Ports:
//   clk              in   1   rising-edge clock
//   rst              in   1   synchronous active-high reset
//   instructionFetch in  32   instruction word at address pc
//   pcenable         in   1   1 = fetch may advance
//   idexNOP          in   1   hold front end, bubble into ID/EX
//   exmemNOP         in   1   hold front end and ID/EX, bubble into EX/MEM
//   branch_taken     in   1   taken branch resolved in EX
//   branch_target    in  32   redirect address
//   pc               out 32   current fetch address
//   instructionDEC/EX/MEM/WB out 32  stage instruction registers
//   stage_valid      out  4   {WB,MEM,EX,DEC} valid bits
//   stall_count      out 16   stall-cycle counter
//
// Configuration macro:
//   STALL_COUNT_EN - when defined, stall_count counts cycles with exmemNOP,
//                    idexNOP or !pcenable and saturates at 16'hFFFF.
//                    When undefined, stall_count is tied to 0.
// ---------------------------------------------------------------------------
module pipe_stage_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instructionFetch,
    input  logic        pcenable,
    input  logic        idexNOP,
    input  logic        exmemNOP,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] instructionDEC,
    output logic [31:0] instructionEX,
    output logic [31:0] instructionMEM,
    output logic [31:0] instructionWB,
    output logic [3:0]  stage_valid,
    output logic [15:0] stall_count
);

    localparam int NUM_STAGES = 4;

    // Stage index: 0 = DEC (IF/ID), 1 = EX, 2 = MEM, 3 = WB.
    logic [31:0] r_pc_reg;
    logic [31:0] w_pc_next;
    logic [31:0] r_instr_reg  [NUM_STAGES];
    logic [31:0] w_instr_next [NUM_STAGES];
    logic [3:0]  r_valid_reg;
    logic [3:0]  w_valid_next;

    // -----------------------------------------------------------------------
    // Next-state selection
    // -----------------------------------------------------------------------
    always_comb begin
        // Defaults: everything holds.
        w_pc_next    = r_pc_reg;
        w_valid_next = r_valid_reg;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_instr_next[i] = r_instr_reg[i];
        end

        // MEM/WB always takes EX/MEM, whichever case applies.
        w_instr_next[3] = r_instr_reg[2];
        w_valid_next[3] = r_valid_reg[2];

        if (exmemNOP) begin
            // A branch sitting in EX is not lost here: EX holds, so it is
            // acted on in the cycle its EX stage finally advances.
            w_instr_next[2] = 32'h0000_0000;
            w_valid_next[2] = 1'b0;
        end else if (branch_taken) begin
            w_pc_next       = branch_target;
            w_instr_next[0] = 32'h0000_0000;
            w_valid_next[0] = 1'b0;
            w_instr_next[1] = 32'h0000_0000;
            w_valid_next[1] = 1'b0;
            w_instr_next[2] = r_instr_reg[1];
            w_valid_next[2] = r_valid_reg[1];
        end else if (idexNOP || !pcenable) begin
            w_instr_next[1] = 32'h0000_0000;
            w_valid_next[1] = 1'b0;
            w_instr_next[2] = r_instr_reg[1];
            w_valid_next[2] = r_valid_reg[1];
        end else begin
            w_pc_next       = r_pc_reg + 32'd4;
            w_instr_next[0] = instructionFetch;
            w_valid_next[0] = 1'b1;
            w_instr_next[1] = r_instr_reg[0];
            w_valid_next[1] = r_valid_reg[0];
            w_instr_next[2] = r_instr_reg[1];
            w_valid_next[2] = r_valid_reg[1];
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_reg    <= 32'h0000_0000;
            r_valid_reg <= 4'b0000;
        end else begin
            r_pc_reg    <= w_pc_next;
            r_valid_reg <= w_valid_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_instr_reg[gi] <= 32'h0000_0000;
                end else begin
                    r_instr_reg[gi] <= w_instr_next[gi];
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Optional stall counter
    // -----------------------------------------------------------------------
`ifdef STALL_COUNT_EN
    logic        w_stall;
    logic [15:0] r_stall_count_reg;

    assign w_stall = exmemNOP || idexNOP || !pcenable;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count_reg <= 16'h0000;
        end else if (w_stall && (r_stall_count_reg != 16'hFFFF)) begin
            r_stall_count_reg <= r_stall_count_reg + 16'd1;
        end
    end

    assign stall_count = r_stall_count_reg;
`else
    assign stall_count = 16'h0000;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign pc             = r_pc_reg;
    assign instructionDEC = r_instr_reg[0];
    assign instructionEX  = r_instr_reg[1];
    assign instructionMEM = r_instr_reg[2];
    assign instructionWB  = r_instr_reg[3];
    assign stage_valid    = r_valid_reg;

endmodule
